// File: rtl/line_buffer_3row.sv
// rtl/line_buffer_3row.sv - two-line history buffer emitting column-aligned rows y-2, y-1, y
// Optional top-border replication is enabled with LB_EDGE_REPLICATE_EN.
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic [8:0]       col_out,
    output logic [8:0]       row_out,
    output logic             frame_done
);

    localparam int         AW       = (PIC_WIDTH > 2) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
    localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);

    // mem0 holds row y-1, mem1 holds row y-2, both indexed by column
    logic [WIDTH-1:0] mem0 [PIC_WIDTH];
    logic [WIDTH-1:0] mem1 [PIC_WIDTH];

    logic [8:0]       col;
    logic [8:0]       row;
    logic [8:0]       cur_col;
    logic [8:0]       cur_row;
    logic [8:0]       nxt_col;
    logic [8:0]       nxt_row;
    logic             last_pix;
    logic             emit;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] win1;
    logic [WIDTH-1:0] win2;

    // sof re-anchors the current pixel at (0,0) whatever the counters say
    always_comb begin
        cur_col = sof ? 9'd0 : col;
        cur_row = sof ? 9'd0 : row;
        addr    = cur_col[AW-1:0];
        rd0     = mem0[addr];
        rd1     = mem1[addr];
    end

    always_comb begin
        nxt_col  = cur_col + 9'd1;
        nxt_row  = cur_row;
        last_pix = 1'b0;
        if (cur_col == COL_LAST) begin
            nxt_col = 9'd0;
            if (cur_row == ROW_LAST) begin
                nxt_row  = 9'd0;
                last_pix = 1'b1;
            end else begin
                nxt_row = cur_row + 9'd1;
            end
        end
    end

`ifdef LB_EDGE_REPLICATE_EN
    // top border: rows 0 and 1 substitute the oldest row available
    always_comb begin
        emit = 1'b1;
        win2 = (cur_row == 9'd0) ? din : rd0;
        if (cur_row == 9'd0) begin
            win1 = din;
        end else if (cur_row == 9'd1) begin
            win1 = rd0;
        end else begin
            win1 = rd1;
        end
    end
`else
    always_comb begin
        emit = (cur_row >= 9'd2);
        win1 = rd1;
        win2 = rd0;
    end
`endif

    // read-before-write: the shift below uses the values read above
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            mem1[addr] <= rd0;
            mem0[addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= 9'd0;
            row        <= 9'd0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            dout1      <= '0;
            dout2      <= '0;
            dout3      <= '0;
            col_out    <= 9'd0;
            row_out    <= 9'd0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                col        <= nxt_col;
                row        <= nxt_row;
                valid_out  <= emit;
                frame_done <= last_pix;
                dout1      <= win1;
                dout2      <= win2;
                dout3      <= din;
                col_out    <= cur_col;
                row_out    <= cur_row;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
// tb/tb_line_buffer_3row.sv - directed vector bench for line_buffer_3row on a 4x4 frame
module tb_line_buffer_3row;

    logic        clk = 1'b0;
    logic        rst;
    logic        sof;
    logic        valid_in;
    logic [23:0] din;
    logic        valid_out;
    logic [23:0] dout1;
    logic [23:0] dout2;
    logic [23:0] dout3;
    logic [8:0]  col_out;
    logic [8:0]  row_out;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    line_buffer_3row #(.WIDTH(24), .PIC_WIDTH(4), .PIC_HEIGHT(4)) dut (
        .clk(clk), .rst(rst), .sof(sof), .valid_in(valid_in), .din(din),
        .valid_out(valid_out), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .col_out(col_out), .row_out(row_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sof;
        logic        vin;
        logic [23:0] din;
        logic        ev;
        logic [23:0] e1;
        logic [23:0] e2;
        logic [23:0] e3;
        logic [8:0]  ec;
        logic [8:0]  er;
        logic        efd;
    } vec_t;

    vec_t        tv[$];
    logic [23:0] last_e3 = '0;
    logic [8:0]  last_c  = '0;
    logic [8:0]  last_r  = '0;

`ifdef LB_EDGE_REPLICATE_EN
    localparam logic REPL = 1'b1;
`else
    localparam logic REPL = 1'b0;
`endif

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // din = base + row*16 + col, so every window value follows from its coordinates
    task automatic add_pix(input logic s, input logic [23:0] base, input int c, input int r, input logic fd);
        vec_t v;
        v.sof = s;
        v.vin = 1'b1;
        v.din = base + 24'(r * 16 + c);
        v.e3  = v.din;
        v.ec  = 9'(c);
        v.er  = 9'(r);
        v.efd = fd;
        v.ev  = REPL || (r >= 2);
        if (r == 0) begin
            v.e1 = v.din;
            v.e2 = v.din;
        end else if (r == 1) begin
            v.e1 = base + 24'(c);
            v.e2 = base + 24'(c);
        end else begin
            v.e1 = base + 24'((r - 2) * 16 + c);
            v.e2 = base + 24'((r - 1) * 16 + c);
        end
        tv.push_back(v);
        last_e3 = v.e3;
        last_c  = v.ec;
        last_r  = v.er;
    endtask

    task automatic add_gap(input logic s);
        vec_t v;
        v.sof = s;
        v.vin = 1'b0;
        v.din = 24'hABCDEF;
        v.ev  = 1'b0;
        v.e1  = '0;
        v.e2  = '0;
        v.e3  = last_e3;
        v.ec  = last_c;
        v.er  = last_r;
        v.efd = 1'b0;
        tv.push_back(v);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid_out"}, -1, 32'(valid_out), 32'd0);
        chk({nm, "_frame_done"}, -1, 32'(frame_done), 32'd0);
        chk({nm, "_dout1"}, -1, 32'(dout1), 32'd0);
        chk({nm, "_dout2"}, -1, 32'(dout2), 32'd0);
        chk({nm, "_dout3"}, -1, 32'(dout3), 32'd0);
        chk({nm, "_col_out"}, -1, 32'(col_out), 32'd0);
        chk({nm, "_row_out"}, -1, 32'(row_out), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        sof      = 1'b0;
        valid_in = 1'b0;
        din      = '0;

        // frame A: continuous, sof on first pixel
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                add_pix(r == 0 && c == 0, 24'h000000, c, r, r == 3 && c == 3);
        // frame B: counters wrap without sof; gaps between pixels, some carrying a stray sof
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                add_pix(1'b0, 24'h000100, c, r, r == 3 && c == 3);
                add_gap(c[0]);
            end
        // partial frame, then sof lands at col 2 row 1 and restarts the frame
        for (int k = 0; k < 6; k++)
            add_pix(1'b0, 24'h000200, k % 4, k / 4, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                add_pix(r == 0 && c == 0, 24'h000300, c, r, r == 3 && c == 3);

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            sof      = tv[i].sof;
            valid_in = tv[i].vin;
            din      = tv[i].din;
            @(posedge clk);
            #1;
            chk("valid_out", i, 32'(valid_out), 32'(tv[i].ev));
            chk("frame_done", i, 32'(frame_done), 32'(tv[i].efd));
            chk("dout3", i, 32'(dout3), 32'(tv[i].e3));
            chk("col_out", i, 32'(col_out), 32'(tv[i].ec));
            chk("row_out", i, 32'(row_out), 32'(tv[i].er));
            if (tv[i].ev) begin
                chk("dout1", i, 32'(dout1), 32'(tv[i].e1));
                chk("dout2", i, 32'(dout2), 32'(tv[i].e2));
            end
        end

        // reset mid-stream with valid_in held high: reset must win
        sof = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1;
            din      = 24'h000400 + 24'(k);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        din = 24'h0004FF;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("midreset");
        rst = 1'b0;
        din = 24'h000500;
        @(posedge clk);
        #1;
        chk("post_rst_col", -1, 32'(col_out), 32'd0);
        chk("post_rst_row", -1, 32'(row_out), 32'd0);
        chk("post_rst_dout3", -1, 32'(dout3), 32'h000500);
        chk("post_rst_valid", -1, 32'(valid_out), 32'(REPL));
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid", -1, 32'(valid_out), 32'd0);
        chk("idle_dout3", -1, 32'(dout3), 32'h000500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
